// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Supervises the system PLL from the free-running reference clock. It drives
//   the PLL reset, qualifies the lock indication, and retries a bounded number
//   of times when lock does not arrive. Once lock has been stable long enough,
//   it releases the downstream active-low resets one after another.
//
//   Optional build macro: PLL_LOCK_LOSS_COUNT_EN
//     When defined, an 8-bit saturating lock_loss_cnt output counts the
//     RUN -> PLL_RST transitions caused by loss of lock.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int NUM_RESETS          = 3,
  parameter int STAGGER_CYCLES      = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               locked,
  input  logic                               sw_reset_req,
  output logic                               pll_rst,
  output logic [NUM_RESETS-1:0]              sys_reset_n,
  output logic                               ready,
  output logic                               fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
`ifdef PLL_LOCK_LOSS_COUNT_EN
  ,
  output logic [7:0]                         lock_loss_cnt
`endif
);

  // One shared cycle counter serves every timed state, so it is sized for
  // the longest interval any state has to measure.
  localparam int REL_SPAN = STAGGER_CYCLES * NUM_RESETS;
  localparam int MAX_AB   = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ?
                            LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX  = (MAX_AB > REL_SPAN) ? MAX_AB : REL_SPAN;
  localparam int CNT_W    = $clog2(CNT_MAX) + 1;
  localparam int RC_W     = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_END  = CNT_W'(REL_SPAN);
  localparam logic [RC_W-1:0]  RETRY_LIMIT  = RC_W'(MAX_RETRIES);
  localparam logic [RC_W-1:0]  RETRY_ONE    = RC_W'(1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t                 state;
  state_t                 state_d;
  logic [CNT_W-1:0]       counter;
  logic [CNT_W-1:0]       counter_d;
  logic [RC_W-1:0]        retry_d;
  logic                   locked_meta;
  logic                   locked_s;
  logic                   pll_rst_d;
  logic                   ready_d;
  logic                   fail_d;
  logic [NUM_RESETS-1:0]  sys_reset_d;

  // Two-flop synchronizer: locked comes from the PLL, asynchronous to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= locked;
      locked_s    <= locked_meta;
    end
  end

  // Next-state, counter and retry bookkeeping; a software request overrides everything.
  always_comb begin
    state_d   = state;
    counter_d = counter;
    retry_d   = retry_count;

    if (sw_reset_req) begin
      state_d   = S_PLL_RST;
      counter_d = '0;
      retry_d   = '0;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (counter == RST_LAST) begin
            state_d   = S_WAIT_LOCK;
            counter_d = '0;
          end else begin
            counter_d = counter + CNT_ONE;
          end
        end

        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d   = S_STABLE;
            counter_d = '0;
          end else if (counter == TIMEOUT_LAST) begin
            counter_d = '0;
            if (retry_count < RETRY_LIMIT) begin
              retry_d = retry_count + RETRY_ONE;
              state_d = S_PLL_RST;
            end else begin
              state_d = S_FAIL;
            end
          end else begin
            counter_d = counter + CNT_ONE;
          end
        end

        S_STABLE: begin
          if (!locked_s) begin
            state_d   = S_WAIT_LOCK;
            counter_d = '0;
          end else if (counter == STABLE_LAST) begin
            state_d   = S_RELEASE;
            counter_d = '0;
          end else begin
            counter_d = counter + CNT_ONE;
          end
        end

        S_RELEASE: begin
          if (!locked_s) begin
            state_d   = S_PLL_RST;
            counter_d = '0;
          end else if ((counter + CNT_ONE) == RELEASE_END) begin
            state_d   = S_RUN;
            counter_d = '0;
          end else begin
            counter_d = counter + CNT_ONE;
          end
        end

        S_RUN: begin
          if (!locked_s) begin
            state_d   = S_PLL_RST;
            counter_d = '0;
            retry_d   = '0;
          end
        end

        S_FAIL: begin
          counter_d = '0;
        end

        default: begin
          state_d   = S_PLL_RST;
          counter_d = '0;
          retry_d   = '0;
        end
      endcase
    end
  end

  // Output values are decoded from the next state so that every output is a flop.
  always_comb begin
    pll_rst_d   = (state_d == S_PLL_RST);
    ready_d     = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
    sys_reset_d = '0;
    if (state_d == S_RUN) begin
      sys_reset_d = '1;
    end else if (state_d == S_RELEASE) begin
      for (int i = 0; i < NUM_RESETS; i++) begin
        sys_reset_d[i] = (counter_d >= CNT_W'(STAGGER_CYCLES * (i + 1)));
      end
    end
  end

  // State, counter and registered outputs; reset lands in PLL_RST with everything held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_PLL_RST;
      counter     <= '0;
      retry_count <= '0;
      pll_rst     <= 1'b1;
      sys_reset_n <= '0;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_d;
      counter     <= counter_d;
      retry_count <= retry_d;
      pll_rst     <= pll_rst_d;
      sys_reset_n <= sys_reset_d;
      ready       <= ready_d;
      fail        <= fail_d;
    end
  end

`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic lock_loss_event;

  assign lock_loss_event = (state == S_RUN) && !locked_s && !sw_reset_req;

  // Saturating count of lock losses seen while running; only reset_n clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_loss_cnt <= 8'd0;
    end else if (lock_loss_event && (lock_loss_cnt != 8'hFF)) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer
//   Directed bench for pll_reset_sequencer with short timing parameters.
//   Expected results are queued before each stimulus step and consumed when
//   the DUT produces the matching observation.
module tb_pll_reset_sequencer;

  localparam int NUM_RESETS = 3;

  logic                  clk;
  logic                  reset_n;
  logic                  locked;
  logic                  sw_reset_req;
  logic                  pll_rst;
  logic [NUM_RESETS-1:0] sys_reset_n;
  logic                  ready;
  logic                  fail;
  logic [1:0]            retry_count;
`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic [7:0]            lock_loss_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_TIMEOUT_CYCLES (64),
    .LOCK_STABLE_CYCLES  (16),
    .MAX_RETRIES         (2),
    .NUM_RESETS          (NUM_RESETS),
    .STAGGER_CYCLES      (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .locked       (locked),
    .sw_reset_req (sw_reset_req),
    .pll_rst      (pll_rst),
    .sys_reset_n  (sys_reset_n),
    .ready        (ready),
    .fail         (fail),
    .retry_count  (retry_count)
`ifdef PLL_LOCK_LOSS_COUNT_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  // Free-running reference clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some wait never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion, required finish before time 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushExp(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed);
    exp_t e;
    if (sb.size() == 0) begin
      e.tag   = "<none>";
      e.value = 32'hDEAD_BEEF;
    end else begin
      e = sb.pop_front();
    end
    compared++;
    assert (observed === e.value && tag == e.tag) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d, expected %0d (queued entry %s)",
             tag, observed, e.value, e.tag);
    end
  endtask

  task automatic expectNow(input string tag, input logic [31:0] expected,
                           input logic [31:0] observed);
    pushExp(tag, expected);
    checkOutput(tag, observed);
  endtask

  task automatic checkResequenced(input string where);
    expectNow({where, "_pll_rst"}, 1, 32'(pll_rst));
    expectNow({where, "_sys_reset_n"}, 0, 32'(sys_reset_n));
    expectNow({where, "_ready"}, 0, 32'(ready));
    expectNow({where, "_fail"}, 0, 32'(fail));
    expectNow({where, "_retry"}, 0, 32'(retry_count));
  endtask

  task automatic swPulse();
    sw_reset_req = 1'b1;
    @(negedge clk);
    sw_reset_req = 1'b0;
  endtask

  // Counts edges until pll_rst drops; the PLL reset pulse is 4 cycles wide.
  task automatic measurePllWidth(input string where);
    int c;
    c = 0;
    pushExp({where, "_pll_width"}, 4);
    do begin
      @(negedge clk);
      c++;
    end while (pll_rst === 1'b1 && c < 20);
    checkOutput({where, "_pll_width"}, 32'(c));
  endtask

  task automatic waitRelease(input string where);
    int c;
    c = 0;
    pushExp({where, "_release_seen"}, 1);
    while (sys_reset_n[0] !== 1'b1 && c < 80) begin
      @(negedge clk);
      c++;
    end
    checkOutput({where, "_release_seen"}, 32'(sys_reset_n[0]));
  endtask

  // Raises locked (optionally dropping it for one cycle at glitch_edge) and
  // records the edge at which each reset output and ready first rise.
  task automatic applyStimulus(input string where, input int glitch_edge);
    int base;
    int r0, r1, r2, rr;
    base = (glitch_edge == 0) ? 23 : glitch_edge + 23;
    pushExp({where, "_rise0"}, 32'(base));
    pushExp({where, "_rise1"}, 32'(base + 4));
    pushExp({where, "_rise2"}, 32'(base + 8));
    pushExp({where, "_ready_rise"}, 32'(base + 8));
    pushExp({where, "_retry"}, 0);
    r0 = 0; r1 = 0; r2 = 0; rr = 0;
    for (int c = 1; c <= 80; c++) begin
      locked = (c != glitch_edge);
      @(negedge clk);
      if (r0 == 0 && sys_reset_n[0] === 1'b1) r0 = c;
      if (r1 == 0 && sys_reset_n[1] === 1'b1) r1 = c;
      if (r2 == 0 && sys_reset_n[2] === 1'b1) r2 = c;
      if (rr == 0 && ready === 1'b1) rr = c;
    end
    locked = 1'b1;
    checkOutput({where, "_rise0"}, 32'(r0));
    checkOutput({where, "_rise1"}, 32'(r1));
    checkOutput({where, "_rise2"}, 32'(r2));
    checkOutput({where, "_ready_rise"}, 32'(rr));
    checkOutput({where, "_retry"}, 32'(retry_count));
  endtask

  initial begin
    int c;
    logic prev_pll;
    logic [1:0] prev_retry;
    logic prev_fail;
    logic sys_seen;

    reset_n      = 1'b0;
    locked       = 1'b0;
    sw_reset_req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    expectNow("rst_pll_rst", 1, 32'(pll_rst));
    expectNow("rst_sys_reset_n", 0, 32'(sys_reset_n));
    expectNow("rst_ready", 0, 32'(ready));
    expectNow("rst_fail", 0, 32'(fail));
    expectNow("rst_retry", 0, 32'(retry_count));

    // Normal bring-up: lock arrives 10 cycles after the PLL reset ends.
    reset_n = 1'b1;
    measurePllWidth("bringup");
    repeat (10) @(negedge clk);
    applyStimulus("bringup", 0);
    expectNow("bringup_pll_low", 0, 32'(pll_rst));

    // Lock loss while running: everything reasserts within three cycles.
    locked = 1'b0;
    repeat (3) @(negedge clk);
    expectNow("lockloss_sys_reset_n", 0, 32'(sys_reset_n));
    expectNow("lockloss_ready", 0, 32'(ready));
    expectNow("lockloss_pll_rst", 1, 32'(pll_rst));
`ifdef PLL_LOCK_LOSS_COUNT_EN
    expectNow("lockloss_cnt", 1, 32'(lock_loss_cnt));
`endif
    measurePllWidth("lockloss");
    applyStimulus("lockloss", 0);

    // sw_reset_req together with lock loss, then a glitchy lock.
    locked = 1'b0;
    swPulse();
    checkResequenced("sw_run");
`ifdef PLL_LOCK_LOSS_COUNT_EN
    expectNow("sw_run_cnt", 1, 32'(lock_loss_cnt));
`endif
    measurePllWidth("glitch");
    applyStimulus("glitch", 9);

    // sw_reset_req in the middle of the staggered release.
    swPulse();
    checkResequenced("sw_run2");
    measurePllWidth("rel");
    waitRelease("rel");
    expectNow("rel_last_held", 0, 32'(sys_reset_n[2]));
    swPulse();
    checkResequenced("sw_release");

    // Asynchronous reset between clock edges during the release.
    waitRelease("arst");
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkResequenced("arst");
`ifdef PLL_LOCK_LOSS_COUNT_EN
    expectNow("arst_cnt", 0, 32'(lock_loss_cnt));
`endif

    // Timeout and retry: lock never arrives.
    locked = 1'b0;
    repeat (2) @(negedge clk);
    pushExp("to_pll_fall", 4);
    pushExp("to_pll_rise", 68);
    pushExp("to_retry", 1068);
    pushExp("to_pll_fall", 72);
    pushExp("to_pll_rise", 136);
    pushExp("to_retry", 2136);
    pushExp("to_pll_fall", 140);
    pushExp("to_fail_rise", 204);
    reset_n    = 1'b1;
    prev_pll   = 1'b1;
    prev_retry = 2'd0;
    prev_fail  = 1'b0;
    sys_seen   = 1'b0;
    for (c = 1; c <= 230; c++) begin
      @(negedge clk);
      if (pll_rst !== prev_pll)
        checkOutput(pll_rst ? "to_pll_rise" : "to_pll_fall", 32'(c));
      if (retry_count !== prev_retry)
        checkOutput("to_retry", 32'(retry_count) * 1000 + 32'(c));
      if (fail !== prev_fail)
        checkOutput("to_fail_rise", 32'(c));
      if (sys_reset_n !== '0) sys_seen = 1'b1;
      prev_pll   = pll_rst;
      prev_retry = retry_count;
      prev_fail  = fail;
    end
    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("[TB] FAIL to_events: observed %0d events still pending, expected 0", sb.size());
      sb.delete();
    end
    expectNow("to_sys_never_released", 0, 32'(sys_seen));
    expectNow("to_fail", 1, 32'(fail));
    expectNow("to_pll_rst", 0, 32'(pll_rst));
    expectNow("to_retry_final", 2, 32'(retry_count));

    // sw_reset_req out of FAIL.
    swPulse();
    checkResequenced("sw_fail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
